// File: rtl/ap_ctrl_pkg.sv
// rtl/ap_ctrl_pkg.sv - shared FSM type and sizing helper for the ap_ctrl driver
package ap_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  // Width needed to count 0..max_out transactions in flight.
  function automatic int out_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/ap_ts_fifo.sv
// rtl/ap_ts_fifo.sv - start-timestamp FIFO; same-cycle push+pop on empty bypasses storage
module ap_ts_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int CW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             bypass, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty_o   = (count_q == '0);
    full_o    = (count_q == CW'(DEPTH));
    bypass    = push_i && pop_i && empty_o;
    do_push   = push_i && !bypass;
    do_pop    = pop_i && !empty_o;
    rd_data_o = empty_o ? wr_data_i : mem_q[rd_ptr_q];
    count_o   = count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// rtl/ap_ctrl_driver.sv - HLS ap_ctrl_chain initiator: overlapped starts, continue back-pressure,
// per-transaction latency and protocol error tracking
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 32,
  parameter int MAX_OUT = 2,
  parameter int DLY_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic [DLY_W-1:0] cfg_cont_delay,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] txn_issued,
  output logic [CNT_W-1:0] txn_done,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic             err_protocol
);
  localparam int OUT_W = out_width(MAX_OUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, issued_q, issued_d, done_q, done_d;
  logic [DLY_W-1:0] delay_q, delay_d, wait_q, wait_d;
  logic [LAT_W-1:0] ts_q, last_q, last_d, max_q, max_d, ts_pop;
  logic [OUT_W-1:0] outstanding, out_nxt;
  logic             start_q, start_d, err_q, err_d, fin_chk_q, fin_chk_d;
  logic             go, start_acc, done_acc, push, pop, fifo_full, fifo_empty, viol;

  ap_ts_fifo #(
    .DEPTH(MAX_OUT),
    .W    (LAT_W),
    .CW   (OUT_W)
  ) u_ts_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_i   (push),
    .pop_i    (pop),
    .wr_data_i(ts_q),
    .rd_data_o(ts_pop),
    .count_o  (outstanding),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    go          = cfg_go && (state_q != S_RUN);
    start_acc   = start_q && ap_ready;
    // wait_q counts cycles ap_done has been pending; delay 0 releases in the same cycle
    ap_continue = (state_q == S_RUN) && ap_done && (wait_q >= delay_q);
    done_acc    = ap_done && ap_continue;
    push        = start_acc && (!fifo_full || done_acc);
    pop         = done_acc && (!fifo_empty || push);
    out_nxt     = outstanding + OUT_W'(push) - OUT_W'(pop);
    viol        = (ap_ready && !start_q) || (ap_done && fifo_empty && !start_acc) ||
                  (fin_chk_q && !ap_idle);

    state_d  = state_q;
    num_d    = num_q;
    delay_d  = delay_q;
    issued_d = issued_q;
    done_d   = done_q;
    last_d   = last_q;
    max_d    = max_q;
    err_d    = err_q | viol;
    wait_d   = (ap_done && !done_acc && state_q == S_RUN) ?
               ((wait_q == '1) ? wait_q : wait_q + DLY_W'(1)) : '0;

    if (start_acc && issued_q != '1) issued_d = issued_q + CNT_W'(1);
    if (done_acc && done_q != '1) done_d = done_q + CNT_W'(1);
    if (pop) begin
      last_d = ts_q - ts_pop;
      if (last_d > max_q) max_d = last_d;
    end
    if (state_q == S_RUN && done_acc && done_d == num_q) state_d = S_FINISH;

    if (go) begin
      num_d    = cfg_num_txn;
      delay_d  = cfg_cont_delay;
      issued_d = '0;
      done_d   = '0;
      last_d   = '0;
      max_d    = '0;
      err_d    = 1'b0;
      wait_d   = '0;
      state_d  = (cfg_num_txn == '0) ? S_FINISH : S_RUN;
    end

    // Built from next-state values, so a raised start naturally holds until ap_ready.
    start_d   = (state_d == S_RUN) && (issued_d < num_d) && (out_nxt < OUT_W'(MAX_OUT));
    fin_chk_d = (state_d == S_FINISH) && ((state_q != S_FINISH) || go);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      delay_q   <= '0;
      issued_q  <= '0;
      done_q    <= '0;
      wait_q    <= '0;
      ts_q      <= '0;
      last_q    <= '0;
      max_q     <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      fin_chk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      delay_q   <= delay_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      wait_q    <= wait_d;
      ts_q      <= ts_q + LAT_W'(1);
      last_q    <= last_d;
      max_q     <= max_d;
      start_q   <= start_d;
      err_q     <= err_d;
      fin_chk_q <= fin_chk_d;
    end
  end

  assign ap_start     = start_q;
  assign busy         = (state_q == S_RUN);
  assign finish       = (state_q == S_FINISH);
  assign txn_issued   = issued_q;
  assign txn_done     = done_q;
  assign last_latency = last_q;
  assign max_latency  = max_q;
  assign err_protocol = err_q;

endmodule
